// File: rtl/booth_pkg.sv
// rtl/booth_pkg.sv - shared Booth digit type, recoder and default sizing
package booth_pkg;

  localparam int DEFAULT_WIDTH    = 8;
  localparam int DEFAULT_APPROX_K = 6;

  typedef enum logic [2:0] {
    ZERO,
    POS1,
    POS2,
    NEG1,
    NEG2
  } booth_digit_t;

  // Group is {y[2i+1], y[2i], y[2i-1]}.
  function automatic booth_digit_t booth_recode(input logic [2:0] grp);
    booth_digit_t d;
    case (grp)
      3'b001, 3'b010: d = POS1;
      3'b011:         d = POS2;
      3'b100:         d = NEG2;
      3'b101, 3'b110: d = NEG1;
      default:        d = ZERO;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/booth_pp_gen.sv
// rtl/booth_pp_gen.sv - one sign-extended, pre-shifted radix-4 Booth partial product
module booth_pp_gen
  import booth_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int SHIFT = 0
) (
  input  logic [WIDTH-1:0]   x,
  input  logic [2:0]         grp,
  output logic [2*WIDTH-1:0] pp
);

  logic [2*WIDTH-1:0] xs;
  logic [2*WIDTH-1:0] mag;

  // Extending before doubling/negating keeps -2 * -2^(WIDTH-1) exact.
  assign xs = {{WIDTH{x[WIDTH-1]}}, x};

  always_comb begin
    mag = '0;
    case (booth_recode(grp))
      POS1:    mag = xs;
      POS2:    mag = xs << 1;
      NEG1:    mag = -xs;
      NEG2:    mag = -(xs << 1);
      default: mag = '0;
    endcase
    pp = mag << SHIFT;
  end

endmodule

// File: rtl/booth_approximate.sv
// rtl/booth_approximate.sv - two-stage radix-4 Booth multiplier with OR-compressed low columns
module booth_approximate
  import booth_pkg::*;
#(
  parameter int WIDTH    = DEFAULT_WIDTH,
  parameter int APPROX_K = DEFAULT_APPROX_K
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  input  logic [WIDTH-1:0]     x,
  input  logic [WIDTH-1:0]     y,
  output logic                 out_valid,
  output logic [2*WIDTH-1:0]   p
);

  localparam int N  = WIDTH / 2;
  localparam int PW = 2 * WIDTH;
  localparam logic [PW-1:0] MASK =
    (APPROX_K == 0) ? '0 : ({PW{1'b1}} >> (PW - APPROX_K));

  logic [WIDTH-1:0] x_r;
  logic [WIDTH-1:0] y_r;
  logic             v_r;
  logic [WIDTH:0]   y_ext;
  logic [PW-1:0]    pp [N];
  logic [PW-1:0]    low;
  logic [PW-1:0]    high;
  logic [PW-1:0]    prod;

  // Appended zero supplies y[-1] for the lowest digit.
  assign y_ext = {y_r, 1'b0};

  for (genvar gi = 0; gi < N; gi++) begin : g_pp
    booth_pp_gen #(
      .WIDTH(WIDTH),
      .SHIFT(2 * gi)
    ) u_pp (
      .x  (x_r),
      .grp(y_ext[2*gi+2:2*gi]),
      .pp (pp[gi])
    );
  end

  // Low columns are OR-merged with no carry chain; high columns add exactly.
  always_comb begin
    low  = '0;
    high = '0;
    for (int i = 0; i < N; i++) begin
      low  = low | (pp[i] & MASK);
      high = high + (pp[i] & ~MASK);
    end
    prod = high | low;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      x_r       <= '0;
      y_r       <= '0;
      v_r       <= 1'b0;
      out_valid <= 1'b0;
      p         <= '0;
    end else begin
      v_r       <= in_valid;
      out_valid <= v_r;
      if (in_valid) begin
        x_r <= x;
        y_r <= y;
      end
      if (v_r) begin
        p <= prod;
      end
    end
  end

endmodule

// File: tb/tb_booth_approximate.sv
// tb/tb_booth_approximate.sv - directed, swept and random checks of booth_approximate
module tb_booth_approximate;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [7:0]  x;
  logic [7:0]  y;
  logic        ov_a;
  logic        ov_e;
  logic [15:0] p_a;
  logic [15:0] p_e;

  always #5 clk = ~clk;

  booth_approximate #(.WIDTH(8), .APPROX_K(6)) dut_a (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .x(x), .y(y),
    .out_valid(ov_a), .p(p_a)
  );

  booth_approximate #(.WIDTH(8), .APPROX_K(0)) dut_e (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .x(x), .y(y),
    .out_valid(ov_e), .p(p_e)
  );

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic        v;
    logic [15:0] pa;
    logic [15:0] pe;
    int          prod;
  } slot_t;

  slot_t hist [2];

  typedef struct {
    logic signed [7:0] x;
    logic signed [7:0] y;
    logic [15:0]       p;
  } vec_t;

  function automatic logic [15:0] golden(input logic signed [7:0] a,
                                         input logic signed [7:0] b,
                                         input int k);
    logic [8:0]  be;
    logic [15:0] mask;
    logic [15:0] low;
    logic [15:0] high;
    logic [15:0] pp;
    int          d;
    be   = {b, 1'b0};
    mask = (k == 0) ? 16'h0 : 16'((33'd1 << k) - 33'd1);
    low  = '0;
    high = '0;
    for (int i = 0; i < 4; i++) begin
      d    = int'(be[2*i]) + int'(be[2*i+1]) - 2 * int'(be[2*i+2]);
      pp   = 16'((d * int'(a)) <<< (2 * i));
      low  = low | (pp & mask);
      high = high + (pp & ~mask);
    end
    return high | low;
  endfunction

  task automatic check1(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b want %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check16(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic clear_hist();
    for (int i = 0; i < 2; i++) hist[i] = '{1'b0, 16'h0, 16'h0, 0};
  endtask

  // Check the slot driven two negedges ago, then drive the next slot.
  task automatic step(input logic v, input logic signed [7:0] a,
                      input logic signed [7:0] b, input logic [15:0] ea);
    int diff;
    int prod;
    @(negedge clk);
    check1("out_valid_approx", ov_a, hist[1].v);
    check1("out_valid_exact", ov_e, hist[1].v);
    if (hist[1].v) begin
      check16("p_approx", p_a, hist[1].pa);
      check16("p_exact", p_e, hist[1].pe);
      diff = int'($signed(p_a)) - hist[1].prod;
      total++;
      if (diff >= 256 || diff <= -256) begin
        bad++;
        $display("FAIL err_bound: got diff %0d want |diff| < 256", diff);
      end
    end
    prod    = int'(a) * int'(b);
    hist[1] = hist[0];
    hist[0] = '{v, ea, 16'(prod), prod};
    in_valid = v;
    x = a;
    y = b;
  endtask

  vec_t vecs [7];

  initial begin
    vecs[0] = '{-8'sd34,  8'sd100, 16'hF2B8};
    vecs[1] = '{-8'sd13,  8'sd12,  16'hFF34};
    vecs[2] = '{-8'sd45,  8'sd15,  16'hFD3D};
    vecs[3] = '{ 8'sd45, -8'sd13,  16'hFD77};
    vecs[4] = '{-8'sd128, -8'sd128, 16'h4000};
    vecs[5] = '{ 8'sd0,   8'sd55,  16'h0000};
    vecs[6] = '{ 8'sd77,  8'sd0,   16'h0000};

    rst_n    = 1'b0;
    in_valid = 1'b1;
    x        = 8'h5A;
    y        = 8'h33;
    clear_hist();

    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check1("rst_out_valid_approx", ov_a, 1'b0);
      check1("rst_out_valid_exact", ov_e, 1'b0);
      check16("rst_p_approx", p_a, 16'h0);
      check16("rst_p_exact", p_e, 16'h0);
      x = x + 8'd17;
    end
    rst_n    = 1'b1;
    in_valid = 1'b0;

    for (int i = 0; i < 7; i++) step(1'b1, vecs[i].x, vecs[i].y, vecs[i].p);

    // Back-to-back stream with a single bubble.
    for (int i = 0; i < 5; i++)
      step(1'b1, 8'(i * 29 - 70), 8'(100 - i * 41), golden(8'(i * 29 - 70), 8'(100 - i * 41), 6));
    step(1'b0, 8'sd3, 8'sd3, 16'h0);
    step(1'b1, -8'sd99, 8'sd127, golden(-8'sd99, 8'sd127, 6));

    for (int xi = 0; xi < 256; xi++)
      for (int yi = 0; yi < 256; yi++)
        step(1'b1, 8'(xi), 8'(yi), golden(8'(xi), 8'(yi), 6));

    for (int i = 0; i < 10000; i++) begin
      logic signed [7:0] ra;
      logic signed [7:0] rb;
      ra = 8'($urandom);
      rb = 8'($urandom);
      step(1'b1, ra, rb, golden(ra, rb, 6));
    end
    step(1'b0, 8'sd0, 8'sd0, 16'h0);
    step(1'b0, 8'sd0, 8'sd0, 16'h0);

    // Reset with data in flight must discard it.
    step(1'b1, 8'sd50, 8'sd3, golden(8'sd50, 8'sd3, 6));
    step(1'b1, -8'sd7, 8'sd9, golden(-8'sd7, 8'sd9, 6));
    @(negedge clk);
    rst_n    = 1'b0;
    in_valid = 1'b1;
    clear_hist();
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check1("midrst_out_valid_approx", ov_a, 1'b0);
      check1("midrst_out_valid_exact", ov_e, 1'b0);
      check16("midrst_p_approx", p_a, 16'h0);
      check16("midrst_p_exact", p_e, 16'h0);
    end
    rst_n    = 1'b1;
    in_valid = 1'b0;
    step(1'b1, 8'sd11, -8'sd6, golden(8'sd11, -8'sd6, 6));
    step(1'b0, 8'sd0, 8'sd0, 16'h0);
    step(1'b0, 8'sd0, 8'sd0, 16'h0);
    step(1'b0, 8'sd0, 8'sd0, 16'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/booth_approximate.md
Name: booth_approximate

Overview:
- Pipelined signed two's-complement WIDTH x WIDTH multiplier for FPGA accelerator datapaths.
- Uses radix-4 (modified) Booth recoding.
- Lower-order product columns use an approximate, carry-free compressor to save energy and latency; upper columns are summed exactly.
- Sits between operand registers and the accumulator of a MAC lane.

Parameters:
- WIDTH, 8, operand width in bits; must be even and at least 4.
- APPROX_K, 6, number of low product columns compressed approximately (0 = exact multiplier); legal range 0..2*WIDTH.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous active-low reset.
- in_valid  input  1  x and y are valid this cycle.
- x  input  WIDTH  multiplicand, signed two's complement.
- y  input  WIDTH  multiplier, signed two's complement (Booth-recoded operand).
- out_valid  output  1  p holds the result of an accepted operand pair.
- p  output  2*WIDTH  approximate signed product.

Behaviour:
- Interface: one clock; reset is synchronous and active-low.
- Reset: on a clk edge with rst_n=0, p=0, out_valid=0 and all pipeline valid bits are cleared. Reset mid-operation discards in-flight data.
- Pipeline: fully pipelined with latency 2. Stage 1 registers x, y and in_valid. Stage 2 computes the product combinationally from the stage-1 registers and registers p and out_valid.
- Throughput: one pair per cycle. No backpressure.
- Invalid cycles: when in_valid=0, the slot carries out_valid=0 two cycles later. p may hold its last value; the bench must not check p when out_valid=0.
- Booth recoding: N=WIDTH/2 digits. Digit d_i is taken from (y[2i+1], y[2i], y[2i-1]), with y[-1]=0.
  - 000 and 111 give 0; 001 and 010 give +1; 011 gives +2.
  - 100 gives -2; 101 and 110 give -1.
- Partial products: PP_i = (d_i * x) << 2i, formed as a 2*WIDTH-bit two's-complement value modulo 2^(2*WIDTH). The negation +1 is folded into the value, and each PP_i is fully sign-extended.
- Approximation, with M = (2^APPROX_K)-1:
  - low = bitwise OR over i of (PP_i & M). No carries are generated into or out of the low region.
  - high = sum over i of (PP_i & ~M), modulo 2^(2*WIDTH).
  - p = high | low.
- APPROX_K=0 yields the exact product.
- Boundary cases:
  - x=-2^(WIDTH-1) with digit -2: the value must still be represented correctly in 2*WIDTH bits. No overflow occurs, because the full product fits.
  - y=0 or x=0 gives p=0.
- The formula above is the golden model. The bench computes it bit-exactly.

Decomposition:
- Shared package booth_pkg holds:
  - the Booth digit typedef (enum ZERO, POS1, POS2, NEG1, NEG2);
  - the recode function for a 3-bit group;
  - the constants WIDTH and APPROX_K defaults.
- One sub-module is natural: booth_pp_gen. It takes x and one 3-bit group and outputs a sign-extended 2*WIDTH-bit partial product. It is instantiated N times with generate.
- The OR/exact compressor and the pipeline registers stay in the top module.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles with in_valid=1 -> out_valid=0 and p=0 throughout. First out_valid appears 2 cycles after the first accepted pair following reset release.
- Defaults (WIDTH=8, APPROX_K=6), with out_valid=1 two cycles after each input:
  - x=-34, y=100 -> p=16'hF2B8 (-3400, exact).
  - x=-13, y=12 -> p=16'hFF34 (-204; exact would be -156).
  - x=-45, y=15 -> p=16'hFD3D (-707).
  - x=45, y=-13 -> p=16'hFD77 (-649).
- APPROX_K=0 build: sweep all 65536 (x,y) pairs -> p equals x*y exactly, including x=y=-128 -> 16'h4000.
- Back-to-back streaming: apply 5 consecutive valid pairs, then one bubble (in_valid=0), then 1 pair -> results emerge in order with latency 2. out_valid is low exactly for the bubble slot.
- Randomized: 10k random pairs at the default APPROX_K -> every p matches the golden model. Also check that |p - x*y| < 2^(APPROX_K+2).
